// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave.
package spi_pkg;

  // SPI mode 0: sclk idles low, data sampled on the rising edge, shifted on the falling edge
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

  localparam int         DEFAULT_DATA_WIDTH = 8;
  localparam logic [7:0] DEFAULT_TX_IDLE    = 8'hFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, plus single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the pin through the synchroniser chain and remember the previous synchronised level
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and edge-history registers
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_sync = sync_q[SYNC_STAGES-1];
  assign o_rise = o_sync & ~prev_q;
  assign o_fall = ~o_sync & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave: oversamples sclk/ss/mosi in the clk domain, deserialises MOSI into
// words with a valid/ready output, and serialises queued words onto MISO MSB first.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE     = DATA_WIDTH'(DEFAULT_TX_IDLE)
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_sclk,
  input  logic                  i_ss,
  input  logic                  i_mosi,
  output logic                  o_miso,
  output logic                  o_miso_oe,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic                  o_overrun
);

  localparam int                CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Synchronised pins and edge pulses
  logic sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s;
  logic sample_pulse, shift_pulse;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_async (i_sclk),
    .o_sync  (),
    .o_rise  (sclk_rise),
    .o_fall  (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_async (i_ss),
    .o_sync  (ss_s),
    .o_rise  (ss_rise),
    .o_fall  (ss_fall)
  );

  // MOSI needs only a level, so it gets a bare synchroniser chain
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Sample on the leading edge and shift on the trailing edge for the configured mode
  assign sample_pulse = (SPI_CPOL ^ SPI_CPHA) ? sclk_fall : sclk_rise;
  assign shift_pulse  = (SPI_CPOL ^ SPI_CPHA) ? sclk_rise : sclk_fall;

  // Frame state and shift registers
  spi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  // Holds only the bits received so far; the last bit joins them directly from mosi_s
  logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_word;
  logic                  word_done;
  logic                  tx_load;

  // Byte-stream side registers
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] tx_hold_q, tx_hold_d;
  logic                  tx_full_q, tx_full_d;
  logic                  rx_accept;
  logic                  tx_write;

  assign rx_word   = {rx_shift_q, mosi_s};
  assign rx_accept = rx_valid_q & i_rx_ready;
  assign tx_write  = i_tx_valid & ~tx_full_q;

  // Frame FSM: bit counting, RX deserialisation and TX serialisation
  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    word_done   = 1'b0;
    tx_load     = 1'b0;
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};

    unique case (state_q)
      ST_IDLE: begin
        if (ss_rise) begin
          state_d   = ST_ACTIVE;
          bit_cnt_d = '0;
          tx_load   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (sample_pulse) begin
          rx_shift_d = rx_word[DATA_WIDTH-2:0];
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            word_done = 1'b1;
            tx_load   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (shift_pulse && (bit_cnt_q != '0)) begin
          // The trailing edge at a word boundary must not disturb the freshly loaded MSB
          tx_shift_d = tx_shift_q << 1;
        end
        // Deselect aborts any partial word; a word completing on this cycle still goes out
        if (ss_fall) begin
          state_d    = ST_IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_load    = 1'b0;
          tx_shift_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tx_load) begin
      tx_shift_d = tx_full_q ? tx_hold_q : TX_IDLE;
    end
  end

  // RX output register with sticky overrun, and TX holding register
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_accept;
    overrun_d  = overrun_q;
    tx_hold_d  = tx_write ? i_tx_data : tx_hold_q;
    // A write on the same cycle as a load refills the register the load just drained
    tx_full_d  = tx_write | (tx_full_q & ~tx_load);

    if (word_done) begin
      if (rx_valid_q && !rx_accept) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = rx_word;
        rx_valid_d = 1'b1;
      end
    end
  end

  // State registers
  // NOTE: data registers are reset too, so o_rx_data and o_miso read 0 out of reset.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mosi_sync_q <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      tx_hold_q   <= '0;
      tx_full_q   <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      tx_hold_q   <= tx_hold_d;
      tx_full_q   <= tx_full_d;
    end
  end

  assign o_miso     = tx_shift_q[DATA_WIDTH-1];
  assign o_miso_oe  = ss_s;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_tx_ready = ~tx_full_q;
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as a mode-0 SPI master running sclk at clk/8.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_sclk = 1'b0;
  logic       i_ss = 1'b0;
  logic       i_mosi = 1'b0;
  logic       o_miso;
  logic       o_miso_oe;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       i_rx_ready = 1'b0;
  logic [7:0] i_tx_data = 8'h00;
  logic       i_tx_valid = 1'b0;
  logic       o_tx_ready;
  logic       o_overrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_sclk     (i_sclk),
    .i_ss       (i_ss),
    .i_mosi     (i_mosi),
    .o_miso     (o_miso),
    .o_miso_oe  (o_miso_oe),
    .o_rx_data  (o_rx_data),
    .o_rx_valid (o_rx_valid),
    .i_rx_ready (i_rx_ready),
    .i_tx_data  (i_tx_data),
    .i_tx_valid (i_tx_valid),
    .o_tx_ready (o_tx_ready),
    .o_overrun  (o_overrun)
  );

  // Inputs change and outputs are sampled on the falling clk edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ss_begin();
    i_ss = 1'b1;
    tick(4);
  endtask

  task automatic ss_end();
    i_ss = 1'b0;
    tick(4);
  endtask

  // Offer one word to the TX holding register, waiting a bounded time for space
  task automatic push_tx(input logic [7:0] d);
    int n;
    n = 0;
    while (!o_tx_ready && n < 20) begin
      tick(1);
      n++;
    end
    vectors++;
    if (o_tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL push_tx_wait: o_tx_ready=%b expected 1", o_tx_ready);
    end
    i_tx_data  = d;
    i_tx_valid = 1'b1;
    tick(1);
    i_tx_valid = 1'b0;
  endtask

  // One full-duplex mode-0 word; optionally checks o_rx_valid timing around the 8th rise
  task automatic spi_xfer(input logic [7:0] m, output logic [7:0] s, input bit chk_lat);
    for (int i = 7; i >= 0; i--) begin
      i_mosi = m[i];
      tick(4);
      s[i]   = o_miso;
      i_sclk = 1'b1;
      if (chk_lat && i == 0) begin
        tick(2);
        vectors++;
        if (o_rx_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL rx_valid_early: o_rx_valid=%b expected 0", o_rx_valid);
        end
        tick(1);
        vectors++;
        if (o_rx_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL rx_valid_latency: o_rx_valid=%b expected 1", o_rx_valid);
        end
        tick(1);
      end else begin
        tick(4);
      end
      i_sclk = 1'b0;
    end
    tick(4);
  endtask

  task automatic test_reset();
    logic [7:0] dummy;
    tick(2);
    i_rst_n = 1'b1;
    tick(2);
    vectors++;
    if ({o_miso, o_miso_oe, o_rx_data, o_rx_valid, o_tx_ready, o_overrun} !== {2'b00, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: miso=%b oe=%b rx=%h v=%b rdy=%b ovr=%b expected 0 0 00 0 1 0",
               o_miso, o_miso_oe, o_rx_data, o_rx_valid, o_tx_ready, o_overrun);
    end
    // Start a frame, queue a word and shift a few bits before pulling reset
    ss_begin();
    push_tx(8'h96);
    for (int i = 0; i < 3; i++) begin
      i_mosi = 1'b1;
      tick(4);
      i_sclk = 1'b1;
      tick(4);
      i_sclk = 1'b0;
    end
    dummy = 8'h00;
    vectors++;
    if ({o_miso_oe, o_tx_ready, o_miso} !== 3'b101) begin
      miscompares++;
      $display("FAIL pre_reset_state: oe=%b rdy=%b miso=%b expected 1 0 1", o_miso_oe, o_tx_ready, o_miso);
    end
    i_rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_miso, o_miso_oe, o_rx_data, o_rx_valid, o_tx_ready, o_overrun} !== {2'b00, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_frame_reset: miso=%b oe=%b rx=%h v=%b rdy=%b ovr=%b expected 0 0 00 0 1 0",
               o_miso, o_miso_oe, o_rx_data, o_rx_valid, o_tx_ready, o_overrun);
    end
    i_ss   = 1'b0;
    i_sclk = 1'b0;
    i_mosi = dummy[0];
    tick(2);
    i_rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_rx();
    logic [7:0] s;
    ss_begin();
    spi_xfer(8'hA5, s, 1'b1);
    vectors++;
    if (o_rx_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL rx_data: got %h expected a5", o_rx_data);
    end
    vectors++;
    if (s !== 8'hFF) begin
      miscompares++;
      $display("FAIL rx_idle_miso: got %h expected ff", s);
    end
    i_rx_ready = 1'b1;
    tick(1);
    vectors++;
    if (o_rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rx_accept_clear: o_rx_valid=%b expected 0", o_rx_valid);
    end
    i_rx_ready = 1'b0;
    ss_end();
  endtask

  task automatic test_tx();
    logic [7:0] s;
    i_rx_ready = 1'b1;
    push_tx(8'h3C);
    vectors++;
    if (o_tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_hold_full: o_tx_ready=%b expected 0", o_tx_ready);
    end
    ss_begin();
    vectors++;
    if (o_tx_ready !== 1'b1 || o_miso_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL tx_load_on_ss: rdy=%b oe=%b expected 1 1", o_tx_ready, o_miso_oe);
    end
    spi_xfer(8'h00, s, 1'b0);
    vectors++;
    if (s !== 8'h3C) begin
      miscompares++;
      $display("FAIL tx_word: got %h expected 3c", s);
    end
    spi_xfer(8'h00, s, 1'b0);
    vectors++;
    if (s !== 8'hFF) begin
      miscompares++;
      $display("FAIL tx_idle_word: got %h expected ff", s);
    end
    ss_end();
    i_rx_ready = 1'b0;
    tick(1);
  endtask

  task automatic test_abort();
    logic [7:0] s;
    logic [7:0] part;
    part = 8'hC8;
    ss_begin();
    for (int i = 7; i >= 3; i--) begin
      i_mosi = part[i];
      tick(4);
      i_sclk = 1'b1;
      tick(4);
      i_sclk = 1'b0;
    end
    tick(4);
    ss_end();
    vectors++;
    if ({o_rx_valid, o_miso, o_miso_oe} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_state: v=%b miso=%b oe=%b expected 0 0 0", o_rx_valid, o_miso, o_miso_oe);
    end
    ss_begin();
    spi_xfer(8'h5A, s, 1'b1);
    vectors++;
    if (o_rx_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL abort_next_word: got %h expected 5a", o_rx_data);
    end
    ss_end();
    i_rx_ready = 1'b1;
    tick(2);
  endtask

  task automatic test_continuous();
    logic [7:0] mw [4] = '{8'hC3, 8'h7E, 8'h01, 8'h80};
    logic [7:0] tw [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] s;
    i_rx_ready = 1'b1;
    push_tx(tw[0]);
    ss_begin();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) push_tx(tw[k+1]);
      spi_xfer(mw[k], s, 1'b0);
      vectors++;
      if (s !== tw[k]) begin
        miscompares++;
        $display("FAIL cont_tx[%0d]: got %h expected %h", k, s, tw[k]);
      end
      vectors++;
      if (o_rx_data !== mw[k]) begin
        miscompares++;
        $display("FAIL cont_rx[%0d]: got %h expected %h", k, o_rx_data, mw[k]);
      end
    end
    ss_end();
    vectors++;
    if (o_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL cont_overrun: got %b expected 0", o_overrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    i_rx_ready = 1'b0;
    ss_begin();
    spi_xfer(8'h11, s, 1'b0);
    spi_xfer(8'h22, s, 1'b0);
    vectors++;
    if ({o_rx_data, o_rx_valid, o_overrun} !== {8'h11, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_overrun: rx=%h v=%b ovr=%b expected 11 1 1", o_rx_data, o_rx_valid, o_overrun);
    end
    ss_end();
    i_rx_ready = 1'b1;
    tick(1);
    i_rx_ready = 1'b0;
    vectors++;
    if ({o_rx_valid, o_overrun} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_sticky: v=%b ovr=%b expected 0 1", o_rx_valid, o_overrun);
    end
  endtask

  initial begin
    test_reset();
    test_rx();
    test_tx();
    test_abort();
    test_continuous();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
